star_scan_ctrl: RTL

STAR_SCAN_CTRL -- requirements
Module: star_scan_ctrl

---
 rtl/star_pkg.sv | 36 +++
 rtl/star_box_hit.sv | 29 ++
 rtl/star_scan_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/star_pkg.sv
// Shared constants and types for the star scan controller.
//   SCAN_WIDTH/SCAN_HEIGHT : image geometry (columns/rows)
//   SCAN_MAX_STARS         : number of stored star-box slots
//   box_t                  : 12-bit box {left,right,top,bottom}, 3 bits each
//   state_t                : scan FSM state encoding
package star_pkg;

  localparam int SCAN_WIDTH     = 6;
  localparam int SCAN_HEIGHT    = 6;
  localparam int SCAN_MAX_STARS = 4;

  localparam int CW    = 3;   // coordinate width
  localparam int AW    = 6;   // image RAM address width
  localparam int BW    = 12;  // packed box width
  localparam int CNT_W = 3;   // star counter width (0..MAX_STARS)
  localparam int IDX_W = 2;   // slot index width

  typedef struct packed {
    logic [CW-1:0] left;
    logic [CW-1:0] right;
    logic [CW-1:0] top;
    logic [CW-1:0] bottom;
  } box_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/star_box_hit.sv
// Inclusive containment test of pixel (x,y) against every valid stored box.
//   x, y   : pixel coordinate under test
//   valid  : per-slot valid bits
//   boxes  : stored boxes, one per slot
//   hit    : 1 when (x,y) lies inside at least one valid box
module star_box_hit
  import star_pkg::*;
#(
  parameter int SLOTS = SCAN_MAX_STARS
) (
  input  logic [CW-1:0]    x,
  input  logic [CW-1:0]    y,
  input  logic [SLOTS-1:0] valid,
  input  box_t [SLOTS-1:0] boxes,
  output logic             hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (valid[i] &&
          (x >= boxes[i].left) && (x <= boxes[i].right) &&
          (y >= boxes[i].top)  && (y <= boxes[i].bottom)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/star_scan_ctrl.sv
// Raster-scans an image RAM for pixels above threshold, hands each new star
// seed to a measurement engine and stores the returned bounding boxes.
//   clk, resetn          : clock, synchronous active-low reset
//   start                : one-cycle scan request (ignored while busy)
//   threshold            : pixel qualifies when ram_q > threshold
//   ram_addr / ram_q     : shared image RAM port (one-cycle read latency)
//   eng_addr             : engine's RAM address, routed out during LAUNCH/WAIT
//   meas_start/x/y       : engine launch pulse and held seed coordinate
//   meas_done/meas_box   : engine completion and measured box
//   rd_idx / rd_box      : combinational result-slot read
//   star_count, busy, done, overflow : scan status
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | scanner drives pixel address
// READ   | RAM read latency cycle, ram_q captured
// CHECK  | threshold and containment test on captured pixel
// LAUNCH | one-cycle meas_start, engine owns RAM
// WAIT   | engine measuring, engine owns RAM
// STORE  | write returned box into next free slot
// DONE   | one-cycle done pulse
module star_scan_ctrl
  import star_pkg::*;
#(
  parameter int WIDTH     = SCAN_WIDTH,
  parameter int HEIGHT    = SCAN_HEIGHT,
  parameter int MAX_STARS = SCAN_MAX_STARS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CW-1:0]    threshold,
  output logic [AW-1:0]    ram_addr,
  input  logic [CW-1:0]    ram_q,
  input  logic [AW-1:0]    eng_addr,
  output logic             meas_start,
  output logic [CW-1:0]    meas_x,
  output logic [CW-1:0]    meas_y,
  input  logic             meas_done,
  input  logic [BW-1:0]    meas_box,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [BW-1:0]    rd_box,
  output logic [CNT_W-1:0] star_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t                 state, state_n;
  logic [CW-1:0]          x, y;
  logic [CW-1:0]          pix;
  logic [MAX_STARS-1:0]   valid;
  box_t [MAX_STARS-1:0]   boxes;
  logic [AW-1:0]          scan_addr;
  logic                   hit, candidate, last_px, full;
  logic                   scan_clear, advance, load_seed, set_ovf, store;
  logic [IDX_W-1:0]       slot;

  star_box_hit #(.SLOTS(MAX_STARS)) u_hit (
    .x     (x),
    .y     (y),
    .valid (valid),
    .boxes (boxes),
    .hit   (hit)
  );

  assign scan_addr = AW'(y) * AW'(WIDTH) + AW'(x);
  assign candidate = (pix > threshold) && !hit;
  assign last_px   = (x == CW'(WIDTH - 1)) && (y == CW'(HEIGHT - 1));
  assign full      = (star_count == CNT_W'(MAX_STARS));
  assign slot      = star_count[IDX_W-1:0];

  // Engine owns the RAM port from launch until its result is taken.
  assign ram_addr   = (state == ST_LAUNCH || state == ST_WAIT) ? eng_addr : scan_addr;
  assign meas_start = (state == ST_LAUNCH);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign rd_box     = boxes[rd_idx];

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    scan_clear = 1'b0;
    advance    = 1'b0;
    load_seed  = 1'b0;
    set_ovf    = 1'b0;
    store      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          scan_clear = 1'b1;
          state_n    = ST_ADDR;
        end
      end
      ST_ADDR:  state_n = ST_READ;
      ST_READ:  state_n = ST_CHECK;
      ST_CHECK: begin
        if (candidate) begin
          if (full) begin
            set_ovf = 1'b1;
            state_n = ST_DONE;
          end else begin
            load_seed = 1'b1;
            state_n   = ST_LAUNCH;
          end
        end else if (last_px) begin
          state_n = ST_DONE;
        end else begin
          advance = 1'b1;
          state_n = ST_ADDR;
        end
      end
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT: begin
        if (meas_done) state_n = ST_STORE;
      end
      ST_STORE: begin
        store = 1'b1;
        if (last_px) begin
          state_n = ST_DONE;
        end else begin
          advance = 1'b1;
          state_n = ST_ADDR;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      pix        <= '0;
      star_count <= '0;
      valid      <= '0;
      overflow   <= 1'b0;
      meas_x     <= '0;
      meas_y     <= '0;
    end else begin
      if (scan_clear) begin
        x          <= '0;
        y          <= '0;
        star_count <= '0;
        valid      <= '0;
        overflow   <= 1'b0;
      end
      if (state == ST_READ) pix <= ram_q;
      if (load_seed) begin
        meas_x <= x;
        meas_y <= y;
      end
      if (set_ovf) overflow <= 1'b1;
      if (store) begin
        valid[slot] <= 1'b1;
        star_count  <= star_count + 1'b1;
      end
      if (advance) begin
        if (x == CW'(WIDTH - 1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // Box payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (store) boxes[slot] <= box_t'(meas_box);
  end

endmodule
